// File: rtl/pong_engine_if.sv
// Pong engine bundle: frame/control inputs and per-frame ball and score outputs.
// The master side drives vsync, start, paddles and speed; the slave is the engine.
interface pong_engine_if #(
   parameter int unsigned SPEED_W = 4,
   parameter int unsigned SCORE_W = 4
);
   logic               vsync_in;
   logic               start;
   logic [11:0]        paddle_l_y;
   logic [11:0]        paddle_r_y;
   logic [SPEED_W-1:0] speed;
   logic [11:0]        ball_x;
   logic [11:0]        ball_y;
   logic [SCORE_W-1:0] score_l;
   logic [SCORE_W-1:0] score_r;
   logic [2:0]         state;
   logic               winner;

   modport master (
      output vsync_in, start, paddle_l_y, paddle_r_y, speed,
      input  ball_x, ball_y, score_l, score_r, state, winner
   );

   modport slave (
      input  vsync_in, start, paddle_l_y, paddle_r_y, speed,
      output ball_x, ball_y, score_l, score_r, state, winner
   );
endinterface

// File: rtl/pong_engine.sv
// Pong engine: ball motion, paddle/wall collision, serve sequencing and scoring per frame.
// Define TWO_PLAYER_EN for a live right paddle; otherwise the right edge is a solid wall.
module pong_engine #(
   parameter int unsigned H_RES       = 800,
   parameter int unsigned V_RES       = 600,
   parameter int unsigned BALL_SIZE   = 16,
   parameter int unsigned PADDLE_W    = 16,
   parameter int unsigned PADDLE_H    = 96,
   parameter int unsigned PADDLE_X_L  = 32,
   parameter int unsigned PADDLE_X_R  = 752,
   parameter int unsigned SPEED_W     = 4,
   parameter int unsigned SCORE_W     = 4,
   parameter int unsigned WIN_SCORE   = 9,
   parameter int unsigned SERVE_DELAY = 60
) (
   input logic          clk,
   input logic          rst,
   pong_engine_if.slave bus
);

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StServe = 3'd1,
      StPlay  = 3'd2,
      StPoint = 3'd3,
      StOver  = 3'd4
   } state_e;

   // Wide enough that ball +/- speed and paddle + height never wrap.
   typedef logic signed [13:0] pos_t;

   localparam int unsigned CntW = $clog2(SERVE_DELAY + 2);

   localparam logic [11:0]        CentreX = 12'((H_RES - BALL_SIZE) / 2);
   localparam logic [11:0]        CentreY = 12'((V_RES - BALL_SIZE) / 2);
   localparam pos_t               XMax    = pos_t'(H_RES - BALL_SIZE);
   localparam pos_t               YMax    = pos_t'(V_RES - BALL_SIZE);
   localparam pos_t               FaceL   = pos_t'(PADDLE_X_L + PADDLE_W);
   localparam pos_t               Ball    = pos_t'(BALL_SIZE);
   localparam pos_t               PadH    = pos_t'(PADDLE_H);
   localparam logic [SCORE_W-1:0] Win     = SCORE_W'(WIN_SCORE);
   localparam logic [CntW-1:0]    Delay   = CntW'(SERVE_DELAY);

   state_e             state_q, state_d;
   logic [11:0]        x_q, x_d, y_q, y_d;
   logic               dx_q, dx_d, dy_q, dy_d;
   logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d;
   logic               winner_q, winner_d;
   logic               scorer_r_q, scorer_r_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic               vsync_q, vsync_qq, tick_q, start_q;

   logic               start_rise, ovl_l, hit_l;
   pos_t               step, xs, ys, nx, ny;
   logic [SCORE_W-1:0] inc_l, inc_r;

   assign start_rise = bus.start & ~start_q;

`ifdef TWO_PLAYER_EN
   localparam pos_t FaceR = pos_t'(PADDLE_X_R - BALL_SIZE);
   logic ovl_r, hit_r;
   assign ovl_r = (ys + Ball > pos_t'(bus.paddle_r_y)) && (ys < pos_t'(bus.paddle_r_y) + PadH);
   assign hit_r = dx_q && (xs <= FaceR) && (nx > FaceR) && ovl_r;
`else
   logic unused_paddle_r;
   assign unused_paddle_r = ^bus.paddle_r_y;
`endif

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      dx_d       = dx_q;
      dy_d       = dy_q;
      score_l_d  = score_l_q;
      score_r_d  = score_r_q;
      winner_d   = winner_q;
      scorer_r_d = scorer_r_q;
      cnt_d      = cnt_q;

      step  = (bus.speed == '0) ? pos_t'(1) : pos_t'(bus.speed);
      xs    = pos_t'(x_q);
      ys    = pos_t'(y_q);
      nx    = dx_q ? xs + step : xs - step;
      ny    = dy_q ? ys + step : ys - step;
      ovl_l = (ys + Ball > pos_t'(bus.paddle_l_y)) && (ys < pos_t'(bus.paddle_l_y) + PadH);
      hit_l = !dx_q && (xs >= FaceL) && (nx < FaceL) && ovl_l;
      inc_l = score_l_q + SCORE_W'(1);
      inc_r = score_r_q + SCORE_W'(1);

      unique case (state_q)
         StIdle: begin
            x_d = CentreX;
            y_d = CentreY;
            if (start_rise) begin
               state_d = StServe;
               cnt_d   = Delay;
            end
         end
         StServe: begin
            x_d = CentreX;
            y_d = CentreY;
            if (tick_q) begin
               if (cnt_q == '0) state_d = StPlay;
               else             cnt_d   = cnt_q - CntW'(1);
            end
         end
         StPlay: begin
            if (tick_q) begin
               if (ny < 0) begin
                  y_d  = '0;
                  dy_d = 1'b1;
               end else if (ny > YMax) begin
                  y_d  = 12'(YMax);
                  dy_d = 1'b0;
               end else begin
                  y_d = 12'(ny);
               end

               if (hit_l) begin
                  x_d  = 12'(FaceL);
                  dx_d = 1'b1;
`ifndef TWO_PLAYER_EN
                  if (score_l_q != '1) score_l_d = inc_l;
`endif
               end
`ifdef TWO_PLAYER_EN
               else if (hit_r) begin
                  x_d  = 12'(FaceR);
                  dx_d = 1'b0;
               end
`endif
               else if (nx < 0) begin
                  state_d    = StPoint;
                  scorer_r_d = 1'b1;
               end else if (nx > XMax) begin
`ifdef TWO_PLAYER_EN
                  state_d    = StPoint;
                  scorer_r_d = 1'b0;
`else
                  x_d  = 12'(XMax);
                  dx_d = 1'b0;
`endif
               end else begin
                  x_d = 12'(nx);
               end
            end
         end
         StPoint: begin
            x_d     = CentreX;
            y_d     = CentreY;
            cnt_d   = Delay;
            state_d = StServe;
            if (scorer_r_q) begin
               score_r_d = inc_r;
               if (inc_r == Win) begin
                  state_d  = StOver;
                  winner_d = 1'b1;
               end
            end else begin
               score_l_d = inc_l;
               if (inc_l == Win) begin
                  state_d  = StOver;
                  winner_d = 1'b0;
               end
            end
`ifdef TWO_PLAYER_EN
            // The player who conceded receives the serve.
            dx_d = ~scorer_r_q;
`else
            dx_d = 1'b1;
`endif
         end
         StOver: begin
            x_d = CentreX;
            y_d = CentreY;
            if (start_rise) begin
               score_l_d = '0;
               score_r_d = '0;
               winner_d  = 1'b0;
               dx_d      = 1'b1;
               cnt_d     = Delay;
               state_d   = StServe;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= StIdle;
         x_q        <= CentreX;
         y_q        <= CentreY;
         dx_q       <= 1'b1;
         dy_q       <= 1'b1;
         score_l_q  <= '0;
         score_r_q  <= '0;
         winner_q   <= 1'b0;
         scorer_r_q <= 1'b0;
         cnt_q      <= '0;
         vsync_q    <= 1'b0;
         vsync_qq   <= 1'b0;
         tick_q     <= 1'b0;
         start_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         dx_q       <= dx_d;
         dy_q       <= dy_d;
         score_l_q  <= score_l_d;
         score_r_q  <= score_r_d;
         winner_q   <= winner_d;
         scorer_r_q <= scorer_r_d;
         cnt_q      <= cnt_d;
         vsync_q    <= bus.vsync_in;
         vsync_qq   <= vsync_q;
         tick_q     <= vsync_q & ~vsync_qq;
         start_q    <= bus.start;
      end
   end

   assign bus.ball_x  = x_q;
   assign bus.ball_y  = y_q;
   assign bus.score_l = score_l_q;
   assign bus.score_r = score_r_q;
   assign bus.state   = state_q;
   assign bus.winner  = winner_q;

endmodule

// File: tb/tb_pong_engine.sv
// Directed bench for pong_engine in the default single-player build: serve, bounces,
// paddle return, misses to match end, restart and mid-play reset.
module tb_pong_engine;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   pong_engine_if #(.SPEED_W(8), .SCORE_W(4)) bus ();

   pong_engine #(
      .SPEED_W    (8),
      .SCORE_W    (4),
      .WIN_SCORE  (9),
      .SERVE_DELAY(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // One frame: vsync pulse, then enough cycles for the tick to land.
   task automatic frame(input int spd);
      bus.speed = 8'(spd);
      @(negedge clk) bus.vsync_in = 1'b1;
      repeat (2) @(negedge clk);
      bus.vsync_in = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic start_pulse();
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic check_ball(input string tag, input int ex, input int ey);
      check({tag, "_x"}, int'(bus.ball_x), ex);
      check({tag, "_y"}, int'(bus.ball_y), ey);
   endtask

   initial begin
      rst            = 1'b0;
      bus.vsync_in   = 1'b0;
      bus.start      = 1'b0;
      bus.paddle_l_y = 12'd100;
      bus.paddle_r_y = 12'd0;
      bus.speed      = 8'd1;
      repeat (2) @(negedge clk);
      check_ball("reset", 392, 292);
      check("reset_state", int'(bus.state), 0);
      check("reset_score_l", int'(bus.score_l), 0);
      check("reset_score_r", int'(bus.score_r), 0);
      check("reset_winner", int'(bus.winner), 0);
      rst = 1'b1;

      repeat (10) frame(1);
      check("idle_hold", int'(bus.state), 0);

      start_pulse();
      check("serve_enter", int'(bus.state), 1);
      for (int i = 0; i < 3; i++) begin
         frame(5);
         check("serve_hold", int'(bus.state), 1);
      end
      frame(5);
      check("serve_to_play", int'(bus.state), 2);
      check_ball("play_start", 392, 292);

      // Tick latency: vsync seen at edge N, position moves at edge N+2; speed 0 acts as 1.
      bus.speed = 8'd0;
      @(negedge clk) bus.vsync_in = 1'b1;
      @(posedge clk);
      @(posedge clk) #1;
      check("lat_n1_x", int'(bus.ball_x), 392);
      @(posedge clk) #1;
      check_ball("lat_n2", 393, 293);
      @(negedge clk) bus.vsync_in = 1'b0;
      repeat (3) @(negedge clk);

      frame(200); check_ball("move", 593, 493);
      frame(187); check_ball("bottom_clamp", 780, 584);
      frame(8);   check_ball("right_wall", 784, 576);
      check("right_wall_no_score", int'(bus.score_l), 0);
      frame(254); check_ball("leftup1", 530, 322);
      frame(254); check_ball("leftup2", 276, 68);
      frame(66);  check_ball("near_top", 210, 2);
      frame(4);   check_ball("top_clamp", 206, 0);
      frame(4);   check_ball("top_bounce", 202, 4);

      frame(150); check_ball("approach", 52, 154);
      frame(6);   check_ball("paddle_ret", 48, 160);
      check("return_score_l", int'(bus.score_l), 1);

      frame(250); check_ball("go_right", 298, 410);
      frame(250); check_ball("go_right2", 548, 584);
      frame(250); check_ball("go_right3", 784, 334);
      bus.paddle_l_y = 12'd400;
      frame(250); check_ball("go_left", 534, 84);
      frame(250); check_ball("go_left2", 284, 0);
      frame(250); check_ball("past_paddle", 34, 250);
      start_pulse();
      check("start_ignored", int'(bus.state), 2);
      frame(50);
      check("miss_state", int'(bus.state), 1);
      check("miss_score_r", int'(bus.score_r), 1);
      check_ball("miss_centre", 392, 292);

      for (int k = 2; k <= 9; k++) begin
         repeat (4) frame(5);
         frame(255);
         check("serve_dx", int'(bus.ball_x), 647);
         repeat (5) frame(255);
         check("loop_score_r", int'(bus.score_r), k);
         check("loop_state", int'(bus.state), (k < 9) ? 1 : 4);
      end
      check("over_winner", int'(bus.winner), 1);
      check("over_score_l", int'(bus.score_l), 1);
      check_ball("over_centre", 392, 292);

      start_pulse();
      check("restart_state", int'(bus.state), 1);
      check("restart_score_l", int'(bus.score_l), 0);
      check("restart_score_r", int'(bus.score_r), 0);
      check("restart_winner", int'(bus.winner), 0);

      repeat (4) frame(5);
      frame(255);
      check("replay_x", int'(bus.ball_x), 647);
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      check("midrst_state", int'(bus.state), 0);
      check_ball("midrst", 392, 292);
      rst = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
